// File: rtl/piso_pkg.sv
// piso_pkg: shared state type for the parallel-in/serial-out converter
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/piso.sv
// piso: loads a MAX_NUM-slice word on valid/ready and emits it slice 0 first, one WIDTH-bit beat per transfer
module piso
  import piso_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MAX_NUM = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH*MAX_NUM-1:0] din_parallel,
  input  logic                     din_valid,
  output logic                     din_ready,
  output logic [WIDTH-1:0]         dout_serial,
  output logic                     dout_valid,
  input  logic                     dout_ready,
  output logic                     dout_last,
  output logic                     busy
);
  localparam int CW = $clog2(MAX_NUM) + 1;
  localparam int TW = WIDTH * MAX_NUM;
  state_t          state;
  logic [TW-1:0]   sr;
  logic [CW-1:0]   cnt;
  logic            in_xfer;
  logic            out_xfer;
  assign dout_valid  = state == SHIFT;
  assign busy        = state == SHIFT;
  assign dout_serial = sr[WIDTH-1:0];
  assign dout_last   = state == SHIFT && cnt == CW'(MAX_NUM - 1);
  // ready on the last beat lets the next word load with no bubble
  assign din_ready   = state == IDLE || (dout_last && dout_ready);
  assign in_xfer     = din_valid && din_ready;
  assign out_xfer    = dout_valid && dout_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
    end else if (in_xfer) begin
      state <= SHIFT;
      sr    <= din_parallel;
      cnt   <= '0;
    end else if (out_xfer) begin
      state <= dout_last ? IDLE : SHIFT;
      sr    <= sr >> WIDTH;
      cnt   <= dout_last ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_piso.sv
// tb_piso: directed checks of piso for MAX_NUM=2 and MAX_NUM=1 plus a random round trip
module tb_piso;
  logic        clk = 0;
  logic        rst = 1;
  logic [15:0] din2 = '0;
  logic        dv2 = 0, dr2, ov2, or2 = 0, ol2, bz2;
  logic [7:0]  ds2;
  logic [7:0]  din1 = '0;
  logic        dv1 = 0, dr1, ov1, or1 = 0, ol1, bz1;
  logic [7:0]  ds1;
  int          nvec = 0, nmis = 0;
  logic [15:0] rxq[$];
  logic [15:0] col = '0;
  logic        rt_on = 0;

  always #5 clk = ~clk;

  piso #(.WIDTH(8), .MAX_NUM(2)) u2 (
    .clk(clk), .rst(rst), .din_parallel(din2), .din_valid(dv2), .din_ready(dr2),
    .dout_serial(ds2), .dout_valid(ov2), .dout_ready(or2), .dout_last(ol2), .busy(bz2)
  );

  piso #(.WIDTH(8), .MAX_NUM(1)) u1 (
    .clk(clk), .rst(rst), .din_parallel(din1), .din_valid(dv1), .din_ready(dr1),
    .dout_serial(ds1), .dout_valid(ov1), .dout_ready(or1), .dout_last(ol1), .busy(bz1)
  );

  // reference collector: reassembles beats, slice 0 first
  always @(posedge clk) begin
    if (rt_on && ov2 && or2) begin
      if (ol2) rxq.push_back({ds2, col[15:8]});
      col <= {ds2, col[15:8]};
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] w3[3];
    logic [7:0]  eb[6];
    logic [15:0] src[100];
    int idx, cyc;
    logic acc;
    w3 = '{16'h1122, 16'h3344, 16'h5566};
    eb = '{8'h22, 8'h11, 8'h44, 8'h33, 8'h66, 8'h55};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_valid", ov2, 0);
    check("rst_busy", bz2, 0);
    check("rst_last", ol2, 0);
    check("rst_serial", ds2, 0);
    check("rst_ready", dr2, 1);
    // basic word
    @(negedge clk);
    din2 = 16'hBEEF; dv2 = 1; or2 = 1;
    #1 check("basic_ready", dr2, 1);
    @(negedge clk);
    dv2 = 0;
    #1;
    check("basic_b0", {ov2, ol2, bz2, ds2}, {3'b101, 8'hEF});
    @(negedge clk);
    #1 check("basic_b1", {ov2, ol2, bz2, ds2}, {3'b111, 8'hBE});
    @(negedge clk);
    #1 check("basic_idle", {ov2, bz2, dr2}, 3'b001);
    // back-to-back words
    idx = 0;
    dv2 = 1; din2 = w3[0];
    #1 acc = dv2 && dr2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (acc) idx++;
      dv2 = idx < 3;
      din2 = idx < 3 ? w3[idx] : 16'h0;
      #1;
      check($sformatf("b2b_beat%0d", i), {ov2, ds2}, {1'b1, eb[i]});
      check($sformatf("b2b_last%0d", i), {ol2, dr2}, {2{i[0]}});
      acc = dv2 && dr2;
    end
    check("b2b_accepts", idx, 3);
    @(negedge clk);
    #1 check("b2b_idle", ov2, 0);
    // backpressure
    din2 = 16'hA5C3; dv2 = 1; or2 = 0;
    @(negedge clk);
    dv2 = 0;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("bp_hold%0d", i), {ov2, ol2, dr2, ds2}, {3'b100, 8'hC3});
      @(negedge clk);
    end
    or2 = 1;
    #1 check("bp_c3", {ov2, ol2, ds2}, {2'b10, 8'hC3});
    @(negedge clk);
    #1 check("bp_a5", {ov2, ol2, ds2}, {2'b11, 8'hA5});
    @(negedge clk);
    #1 check("bp_idle", ov2, 0);
    // reset mid-word
    din2 = 16'h1234; dv2 = 1;
    @(negedge clk);
    dv2 = 0;
    #1 check("rmw_b0", ds2, 8'h34);
    @(negedge clk);
    rst = 1; or2 = 0;
    @(negedge clk);
    rst = 0;
    #1 check("rmw_after", {ov2, bz2, dr2, ds2}, {3'b001, 8'h00});
    or2 = 1;
    @(negedge clk);
    #1 check("rmw_nobeat", ov2, 0);
    // MAX_NUM=1
    idx = 0; or1 = 1; dv1 = 1; din1 = 8'h01;
    #1 acc = dv1 && dr1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (acc) idx++;
      dv1 = idx < 3;
      din1 = 8'(idx + 1);
      #1;
      check($sformatf("m1_beat%0d", i), {ov1, ol1, dr1, ds1}, {3'b111, 8'(i + 1)});
      acc = dv1 && dr1;
    end
    @(negedge clk);
    dv1 = 0;
    #1 check("m1_idle", {ov1, bz1}, 2'b00);
    // random round trip with random backpressure
    for (int i = 0; i < 100; i++) src[i] = 16'($urandom);
    rt_on = 1; idx = 0; acc = 0; cyc = 0;
    while (rxq.size() < 100 && cyc < 3000) begin
      @(negedge clk);
      if (acc) idx++;
      dv2 = idx < 100 && $urandom_range(0, 3) != 0;
      din2 = idx < 100 ? src[idx] : 16'h0;
      or2 = $urandom_range(0, 3) != 0;
      #1 acc = dv2 && dr2;
      cyc++;
    end
    dv2 = 0;
    check("rt_count", rxq.size(), 100);
    for (int i = 0; i < 100 && i < rxq.size(); i++)
      check($sformatf("rt_word%0d", i), rxq[i], src[i]);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
